// File: rtl/controlador_estados_if.sv
// ---------------------------------------------------------------------------
// controlador_estados_if
// Purpose: groups the player buttons, the attribute levels and the behaviour
//          code produced by the Tamagotchi behaviour FSM.
// Signals:
//   btn_iniciar/btn_dormir/btn_comer/btn_aula  button levels, async to clk
//   fome/felicidade/sono                      attribute levels 0..100
//   estado                                    5-bit one-hot behaviour code
//   mudou_estado                              one-cycle pulse on estado change
// Modports: master = stimulus/attribute side, slave = the FSM itself.
// ---------------------------------------------------------------------------
interface controlador_estados_if;
    logic       btn_iniciar;
    logic       btn_dormir;
    logic       btn_comer;
    logic       btn_aula;
    logic [7:0] fome;
    logic [7:0] felicidade;
    logic [7:0] sono;
    logic [4:0] estado;
    logic       mudou_estado;

    modport master (
        output btn_iniciar, btn_dormir, btn_comer, btn_aula,
        output fome, felicidade, sono,
        input  estado, mudou_estado
    );

    modport slave (
        input  btn_iniciar, btn_dormir, btn_comer, btn_aula,
        input  fome, felicidade, sono,
        output estado, mudou_estado
    );
endinterface

// File: rtl/controlador_estados.sv
// ---------------------------------------------------------------------------
// controlador_estados
// Purpose: Tamagotchi behaviour FSM. Turns button presses and attribute
//          levels into the one-hot estado code; handles start/restart,
//          activity selection, activity auto-end, timeout and death.
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   controlador_estados_if.slave (buttons, attributes, estado,
//         mudou_estado)
// Parameters:
//   MAX_ATRIB  attribute ceiling; an activity ends once its target >= this
//   TIMEOUT_W  width of the activity timer; all-ones ends the activity
// ---------------------------------------------------------------------------
module controlador_estados #(
    parameter logic [7:0] MAX_ATRIB = 8'd100,
    parameter int         TIMEOUT_W = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    controlador_estados_if.slave  bus
);

    localparam logic [4:0] ST_INTRO      = 5'b00000;
    localparam logic [4:0] ST_IDLE       = 5'b00001;
    localparam logic [4:0] ST_DORMINDO   = 5'b00010;
    localparam logic [4:0] ST_COMENDO    = 5'b00100;
    localparam logic [4:0] ST_DANDO_AULA = 5'b01000;
    localparam logic [4:0] ST_MORTO      = 5'b10000;

    // Button bit positions inside the press vector.
    localparam int B_INI = 0;
    localparam int B_DOR = 1;
    localparam int B_COM = 2;
    localparam int B_AUL = 3;

    logic [3:0]           w_btn;
    logic [3:0]           r_sync1;
    logic [3:0]           r_sync2;
    logic [3:0]           r_prev;
    logic [3:0]           r_press;
    logic [4:0]           r_estado;
    logic [4:0]           w_next_estado;
    logic                 r_mudou;
    logic [TIMEOUT_W-1:0] r_timer;
    logic                 w_morte;
    logic                 w_timeout;
    logic                 w_mudou_next;
    logic                 w_em_atividade;

    assign w_btn     = {bus.btn_aula, bus.btn_comer, bus.btn_dormir, bus.btn_iniciar};
    assign w_morte   = (bus.fome == 8'd0) | (bus.felicidade == 8'd0) | (bus.sono == 8'd0);
    assign w_timeout = &r_timer;

    // Button synchronisers and rising-edge detection. The sync/prev flops
    // reset high so a button held through reset does not count as a press;
    // the press itself is registered, so estado reacts three edges after the
    // first edge that samples the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
            r_prev  <= 4'b1111;
            r_press <= 4'b0000;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_press <= r_sync2 & ~r_prev;
        end
    end

    // State register, change pulse and activity timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= ST_INTRO;
            r_mudou  <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_estado <= w_next_estado;
            r_mudou  <= w_mudou_next;
            if (w_mudou_next) begin
                r_timer <= '0;
            end else if (w_em_atividade) begin
                // Cannot wrap: all-ones always leaves the activity first.
                r_timer <= r_timer + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
            end else begin
                r_timer <= r_timer;
            end
        end
    end

    // Next-state logic; first matching condition wins inside each state.
    always_comb begin
        w_next_estado = r_estado;
        case (r_estado)
            ST_INTRO: begin
                if (r_press[B_INI]) w_next_estado = ST_IDLE;
                else                w_next_estado = ST_INTRO;
            end
            ST_IDLE: begin
                // Presses on a saturated target fall through and are lost.
                if (w_morte)                                       w_next_estado = ST_MORTO;
                else if (r_press[B_DOR] && (bus.sono < MAX_ATRIB))       w_next_estado = ST_DORMINDO;
                else if (r_press[B_COM] && (bus.fome < MAX_ATRIB))       w_next_estado = ST_COMENDO;
                else if (r_press[B_AUL] && (bus.felicidade < MAX_ATRIB)) w_next_estado = ST_DANDO_AULA;
                else                                               w_next_estado = ST_IDLE;
            end
            ST_DORMINDO: begin
                if (w_morte)                                                  w_next_estado = ST_MORTO;
                else if ((bus.sono >= MAX_ATRIB) || r_press[B_DOR] || w_timeout) w_next_estado = ST_IDLE;
                else                                                          w_next_estado = ST_DORMINDO;
            end
            ST_COMENDO: begin
                if (w_morte)                                                  w_next_estado = ST_MORTO;
                else if ((bus.fome >= MAX_ATRIB) || r_press[B_COM] || w_timeout) w_next_estado = ST_IDLE;
                else                                                          w_next_estado = ST_COMENDO;
            end
            ST_DANDO_AULA: begin
                if (w_morte)                                                        w_next_estado = ST_MORTO;
                else if ((bus.felicidade >= MAX_ATRIB) || r_press[B_AUL] || w_timeout) w_next_estado = ST_IDLE;
                else                                                                w_next_estado = ST_DANDO_AULA;
            end
            ST_MORTO: begin
                if (r_press[B_INI]) w_next_estado = ST_INTRO;
                else                w_next_estado = ST_MORTO;
            end
            default: begin
                // Any non-listed code recovers to INTRO.
                w_next_estado = ST_INTRO;
            end
        endcase
    end

    // Output decode: change flag and timer enable for the registered outputs.
    always_comb begin
        w_mudou_next   = (w_next_estado != r_estado);
        w_em_atividade = 1'b0;
        case (r_estado)
            ST_DORMINDO, ST_COMENDO, ST_DANDO_AULA: w_em_atividade = 1'b1;
            default:                                w_em_atividade = 1'b0;
        endcase
    end

    assign bus.estado       = r_estado;
    assign bus.mudou_estado = r_mudou;

endmodule

// File: tb/tb_controlador_estados.sv
module tb_controlador_estados;

    localparam logic [4:0] INTRO      = 5'b00000;
    localparam logic [4:0] IDLE       = 5'b00001;
    localparam logic [4:0] DORMINDO   = 5'b00010;
    localparam logic [4:0] COMENDO    = 5'b00100;
    localparam logic [4:0] DANDO_AULA = 5'b01000;
    localparam logic [4:0] MORTO      = 5'b10000;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   at_e;

    typedef struct {
        logic [4:0] st;
        int         at;
    } exp_t;
    exp_t q[$];

    controlador_estados_if bus_if ();

    controlador_estados #(.MAX_ATRIB(8'd100), .TIMEOUT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every mudou_estado pulse must match the next queued expectation,
    // both in new estado value and in the edge at which it appeared.
    always @(negedge clk) begin
        if (bus_if.mudou_estado === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: estado=%b at edge %0d, none expected", bus_if.estado, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus_if.estado !== e.st || cyc != e.at) begin
                    bad++;
                    $display("FAIL change: got estado=%b at edge %0d, want %b at edge %0d",
                             bus_if.estado, cyc, e.st, e.at);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] m);
        bus_if.btn_iniciar = m[0];
        bus_if.btn_dormir  = m[1];
        bus_if.btn_comer   = m[2];
        bus_if.btn_aula    = m[3];
    endtask

    // Raise the masked buttons at a negedge; the new estado shows 4 edges later.
    task automatic press(input logic [3:0] m, input logic exp_chg, input logic [4:0] exp_st,
                         output int at);
        at = cyc + 4;
        if (exp_chg) q.push_back('{exp_st, at});
        set_btn(m);
        repeat (4) @(negedge clk);
        set_btn(4'b0000);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_btn(4'b0001);
        bus_if.fome = 8'd50;
        bus_if.felicidade = 8'd50;
        bus_if.sono = 8'd50;
        repeat (2) @(negedge clk);
        chk("reset_estado", bus_if.estado, INTRO);
        chk("reset_mudou", bus_if.mudou_estado, 1'b0);
        chk("reset_timer", dut.r_timer, 4'd0);

        // Button held through reset is not a press.
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_not_press", bus_if.estado, INTRO);
        set_btn(4'b0000);

        // Death ignored in INTRO.
        bus_if.fome = 8'd0;
        repeat (4) @(negedge clk);
        chk("intro_ignora_morte", bus_if.estado, INTRO);
        bus_if.fome = 8'd50;
        @(negedge clk);

        press(4'b0001, 1'b1, IDLE, at_e);
        chk("inicia_idle", bus_if.estado, IDLE);

        // Sleep, then sono saturates: back to IDLE on the next edge.
        press(4'b0010, 1'b1, DORMINDO, at_e);
        chk("entra_dormindo", bus_if.estado, DORMINDO);
        bus_if.sono = 8'd100;
        q.push_back('{IDLE, cyc + 1});
        @(negedge clk);
        chk("sono_cheio_idle", bus_if.estado, IDLE);
        bus_if.sono = 8'd50;
        @(negedge clk);

        // Simultaneous presses: dormir wins; pressing dormir again ends it.
        press(4'b1110, 1'b1, DORMINDO, at_e);
        chk("prioridade_dormir", bus_if.estado, DORMINDO);
        press(4'b0010, 1'b1, IDLE, at_e);
        chk("dormir_encerra", bus_if.estado, IDLE);

        // Saturated target: press discarded.
        bus_if.fome = 8'd100;
        press(4'b0100, 1'b0, IDLE, at_e);
        chk("comer_saturado", bus_if.estado, IDLE);
        bus_if.fome = 8'd60;
        @(negedge clk);

        // Timeout: timer runs 0..15 in COMENDO, IDLE on the 16th edge after entry.
        press(4'b0100, 1'b1, COMENDO, at_e);
        chk("entra_comendo", bus_if.estado, COMENDO);
        q.push_back('{IDLE, at_e + 16});
        repeat (at_e + 17 - cyc) @(negedge clk);
        chk("timeout_idle", bus_if.estado, IDLE);

        // Death during an activity, MORTO ignores activity buttons, iniciar restarts.
        press(4'b1000, 1'b1, DANDO_AULA, at_e);
        chk("entra_aula", bus_if.estado, DANDO_AULA);
        bus_if.felicidade = 8'd0;
        q.push_back('{MORTO, cyc + 1});
        @(negedge clk);
        chk("morre", bus_if.estado, MORTO);
        press(4'b1000, 1'b0, MORTO, at_e);
        chk("morto_ignora_aula", bus_if.estado, MORTO);
        bus_if.felicidade = 8'd50;
        press(4'b0001, 1'b1, INTRO, at_e);
        chk("morto_reinicia", bus_if.estado, INTRO);

        // Reset mid-activity.
        press(4'b0001, 1'b1, IDLE, at_e);
        press(4'b0010, 1'b1, DORMINDO, at_e);
        chk("pre_rst_dormindo", bus_if.estado, DORMINDO);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_estado", bus_if.estado, INTRO);
        chk("rst_timer", dut.r_timer, 4'd0);
        chk("rst_mudou", bus_if.mudou_estado, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("fila_vazia", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
